// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating-counter state.
// Zero-latency fetch lookup, decode-aligned state/hit registers, FSM write-back.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   pc_f              fetch PC (word aligned)
//   stall_f, flush_d  hold / clear the decode-side registers
//   predict_taken_f   comb: hit and counter msb set
//   predicted_pc_f    comb: stored target if taken, else pc_f+4
//   branch_state_d    registered counter state of looked-up entry
//   hit_d             registered lookup hit
//   upd_valid         write strobe from the prediction FSM
//   upd_address       PC of the resolved branch
//   upd_target        resolved taken target
//   upd_state         new counter state
module branch_target_buffer #(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 30 - IDX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic        stall_f,
  input  logic        flush_d,
  output logic        predict_taken_f,
  output logic [31:0] predicted_pc_f,
  output logic [1:0]  branch_state_d,
  output logic        hit_d,
  input  logic        upd_valid,
  input  logic [31:0] upd_address,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_state
);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          state_q  [ENTRIES];

  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] pc_tag;
  logic [IDX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0] u_tag;
  logic                hit;
  logic [1:0]          lk_state;

  // Low address bits carry no information for word-aligned PCs.
  logic unused_lsbs;
  assign unused_lsbs = ^{pc_f[1:0], upd_address[1:0]};

  assign idx    = pc_f[IDX_BITS+1:2];
  assign pc_tag = pc_f[31:IDX_BITS+2];
  assign u_idx  = upd_address[IDX_BITS+1:2];
  assign u_tag  = upd_address[31:IDX_BITS+2];

  // Gating with rst keeps predictions off for the whole reset window.
  assign hit = !rst && valid_q[idx]
            && (tag_q[idx] == pc_tag);

  assign lk_state = hit ? state_q[idx] : 2'b00;

  assign predict_taken_f = hit && lk_state[1];

  assign predicted_pc_f = predict_taken_f
                        ? target_q[idx]
                        : pc_f + 32'd4;

  // Entry storage: flops so reset can clear every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        state_q[i]  <= 2'b00;
      end
    end else if (upd_valid) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
      state_q[u_idx]  <= upd_state;
    end
  end

  // Decode-stage registers: flush beats stall beats load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_state_d <= 2'b00;
      hit_d          <= 1'b0;
    end else if (flush_d) begin
      branch_state_d <= 2'b00;
      hit_d          <= 1'b0;
    end else if (!stall_f) begin
      branch_state_d <= lk_state;
      hit_d          <= hit;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer.
// Comb outputs checked mid-cycle; decode registers via a scoreboard queue.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        stall_f;
  logic        flush_d;
  logic        predict_taken_f;
  logic [31:0] predicted_pc_f;
  logic [1:0]  branch_state_d;
  logic        hit_d;
  logic        upd_valid;
  logic [31:0] upd_address;
  logic [31:0] upd_target;
  logic [1:0]  upd_state;

  branch_target_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .pc_f            (pc_f),
    .stall_f         (stall_f),
    .flush_d         (flush_d),
    .predict_taken_f (predict_taken_f),
    .predicted_pc_f  (predicted_pc_f),
    .branch_state_d  (branch_state_d),
    .hit_d           (hit_d),
    .upd_valid       (upd_valid),
    .upd_address     (upd_address),
    .upd_target      (upd_target),
    .upd_state       (upd_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       hit;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  // Drive one cycle: check comb outputs before the edge,
  // queue the decode expectation, pop/compare after it.
  task automatic step(input string tag,
                      input logic [31:0] pc,
                      input logic stall, input logic flush,
                      input logic uv, input logic [31:0] ua,
                      input logic [31:0] ut, input logic [1:0] us,
                      input logic e_tk, input logic [31:0] e_ppc,
                      input logic e_hit, input logic [1:0] e_st);
    exp_t e;
    @(negedge clk);
    pc_f = pc; stall_f = stall; flush_d = flush;
    upd_valid = uv; upd_address = ua;
    upd_target = ut; upd_state = us;
    #1;
    chk({tag, ".tk"}, {31'd0, predict_taken_f}, {31'd0, e_tk});
    chk({tag, ".ppc"}, predicted_pc_f, e_ppc);
    e.tag = tag; e.hit = e_hit; e.st = e_st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".hit_d"}, {31'd0, hit_d}, {31'd0, e.hit});
      chk({e.tag, ".st_d"}, {30'd0, branch_state_d}, {30'd0, e.st});
    end
  endtask

  initial begin
    rst = 1'b1; pc_f = 32'h40; stall_f = 1'b0; flush_d = 1'b0;
    upd_valid = 1'b0; upd_address = '0;
    upd_target = '0; upd_state = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.tk", {31'd0, predict_taken_f}, 32'd0);
    chk("rst.ppc", predicted_pc_f, 32'h44);
    chk("rst.hit_d", {31'd0, hit_d}, 32'd0);
    chk("rst.st_d", {30'd0, branch_state_d}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: empty buffer
    step("t1", 32'h40, 0, 0, 0, 0, 0, 2'b00, 0, 32'h44, 0, 2'b00);
    // 2: install strongly-taken entry, no same-cycle bypass
    step("t2a", 32'h40, 0, 0, 1, 32'h40, 32'h100, 2'b11, 0, 32'h44, 0, 2'b00);
    step("t2b", 32'h40, 0, 0, 0, 0, 0, 2'b00, 1, 32'h100, 1, 2'b11);
    // 3: downgrade to weakly not taken
    step("t3a", 32'h40, 0, 0, 1, 32'h40, 32'h100, 2'b01, 1, 32'h100, 1, 2'b11);
    step("t3b", 32'h40, 0, 0, 0, 0, 0, 2'b00, 0, 32'h44, 1, 2'b01);
    // 4: restore 11, then alias 0x440 evicts it
    step("t4a", 32'h40, 0, 0, 1, 32'h40, 32'h100, 2'b11, 0, 32'h44, 1, 2'b01);
    step("t4b", 32'h40, 0, 0, 1, 32'h440, 32'h200, 2'b10, 1, 32'h100, 1, 2'b11);
    step("t4c", 32'h40, 0, 0, 0, 0, 0, 2'b00, 0, 32'h44, 0, 2'b00);
    step("t4d", 32'h440, 0, 0, 0, 0, 0, 2'b00, 1, 32'h200, 1, 2'b10);
    // 5: reload 0x40/11, stall three cycles, then flush+stall
    step("t5a", 32'h440, 0, 0, 1, 32'h40, 32'h100, 2'b11, 1, 32'h200, 1, 2'b10);
    step("t5b", 32'h40, 0, 0, 0, 0, 0, 2'b00, 1, 32'h100, 1, 2'b11);
    step("t5s1", 32'h80, 1, 0, 0, 0, 0, 2'b00, 0, 32'h84, 1, 2'b11);
    step("t5s2", 32'h84, 1, 0, 0, 0, 0, 2'b00, 0, 32'h88, 1, 2'b11);
    step("t5s3", 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 2'b00, 0, 32'h0, 1, 2'b11);
    step("t5f", 32'h40, 1, 1, 0, 0, 0, 2'b00, 1, 32'h100, 0, 2'b00);
    // 6: same-cycle update and lookup of 0x80
    step("t6a", 32'h80, 0, 0, 1, 32'h80, 32'h300, 2'b11, 0, 32'h84, 0, 2'b00);
    step("t6b", 32'h80, 0, 0, 0, 0, 0, 2'b00, 1, 32'h300, 1, 2'b11);
    step("t6c", 32'h80, 0, 0, 0, 0, 0, 2'b00, 1, 32'h300, 1, 2'b11);

    // Mid-stream reset with a coincident update that must be dropped
    @(negedge clk);
    upd_valid = 1'b1; upd_address = 32'h84;
    upd_target = 32'h500; upd_state = 2'b11;
    pc_f = 32'h80; rst = 1'b1;
    #1;
    chk("mrst.tk", {31'd0, predict_taken_f}, 32'd0);
    chk("mrst.ppc", predicted_pc_f, 32'h84);
    chk("mrst.hit_d", {31'd0, hit_d}, 32'd0);
    chk("mrst.st_d", {30'd0, branch_state_d}, 32'd0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step("r1", 32'h80, 0, 0, 0, 0, 0, 2'b00, 0, 32'h84, 0, 2'b00);
    step("r2", 32'h84, 0, 0, 0, 0, 0, 2'b00, 0, 32'h88, 0, 2'b00);

    chk("sb.drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Direct-mapped branch target buffer (BTB) with a per-entry 2-bit saturating-counter state. In the fetch stage it looks up the fetch PC and supplies the predicted next PC. It carries the entry's prediction state into decode through registered outputs, which feed the branch prediction FSM. It writes back the FSM's next state and the resolved target when the FSM asserts its valid output.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, minimum 2.
IDX_BITS, 4, log2(ENTRIES); index field = pc[IDX_BITS+1:2].
TAG_BITS, 26, 30-IDX_BITS; tag field = pc[31:IDX_BITS+2].

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
pc_f  in  32  fetch-stage PC (word aligned).
stall_f  in  1  hazard stall; holds the decode-side output registers.
flush_d  in  1  pipeline flush; clears the decode-side output registers.
predict_taken_f  out  1  combinational: lookup hit and counter state[1]==1.
predicted_pc_f  out  32  combinational: stored target if predict_taken_f, else pc_f+4.
branch_state_d  out  2  registered counter state of the looked-up entry, aligned to the decode stage.
hit_d  out  1  registered lookup-hit flag, aligned to the decode stage.
upd_valid  in  1  update strobe; driven by the FSM valid output.
upd_address  in  32  PC of the resolved branch or jump.
upd_target  in  32  resolved taken target.
upd_state  in  2  new counter state; driven by the FSM branch_next_state output.

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (32), state (2). Encoding: 00 strongly not taken, 01 weakly not taken, 10 weakly taken, 11 strongly taken.
- Lookup (combinational, zero latency):
  - idx = pc_f[IDX_BITS+1:2].
  - hit = valid[idx] && tag[idx]==pc_f[31:IDX_BITS+2].
  - predict_taken_f = hit && state[idx][1].
  - predicted_pc_f = predict_taken_f ? target[idx] : pc_f+4. Addition is modulo 2^32; pc 0xFFFFFFFC gives 0x00000000.
- Lookup state on a miss is 2'b00 (strongly not taken).
- Decode registers, evaluated each rising edge with priority flush_d > stall_f > load:
  - flush_d=1: branch_state_d<=00, hit_d<=0.
  - else stall_f=1: hold both registers.
  - else: branch_state_d <= (hit ? state[idx] : 00), hit_d <= hit.
- Update, on a rising edge with upd_valid=1, to entry u = upd_address[IDX_BITS+1:2]:
  - valid<=1, tag<=upd_address[31:IDX_BITS+2], target<=upd_target, state<=upd_state.
  - Overwrites unconditionally, evicting any aliasing entry with a different tag.
  - Updates are independent of stall_f and flush_d.
- Simultaneous update and lookup of the same index:
  - No bypass. Same-cycle lookup outputs and the decode registers loaded on that edge reflect the old contents.
  - The new contents are visible from the next cycle.
- upd_address[1:0] and pc_f[1:0] are ignored.
- Reset (asynchronous, active-high):
  - All valid bits 0, all state fields 00, all target and tag fields 0.
  - branch_state_d=00, hit_d=0.
  - While rst is high: predict_taken_f=0 and predicted_pc_f=pc_f+4.
  - Reset asserted mid-operation discards all entries immediately; an update on the edge coinciding with reset is dropped.
- No other state. Implementation is registers or flops, not an inferred RAM, because reset must clear all entries.

Test Plan:
1. Reset, then pc_f=0x00000040 -> predict_taken_f=0, predicted_pc_f=0x00000044; next edge hit_d=0, branch_state_d=00.
2. Update upd_address=0x40, upd_target=0x100, upd_state=11; next cycle pc_f=0x40 -> predict_taken_f=1, predicted_pc_f=0x100; following edge hit_d=1, branch_state_d=11.
3. Update 0x40 with upd_state=01 -> lookup 0x40 gives predict_taken_f=0, predicted_pc_f=0x44, branch_state_d=01.
4. Entry 0x40 holds state 11; update alias 0x440 (ENTRIES=16) with target 0x200, state 10 -> lookup 0x40 misses (pc+4, state_d 00); lookup 0x440 predicts 0x200.
5. With hit_d=1 and branch_state_d=11 loaded, hold stall_f=1 for 3 cycles while pc_f changes -> outputs hold. Then assert flush_d and stall_f together -> branch_state_d=00, hit_d=0.
6. Same-cycle upd_valid for 0x80 (state 11) with pc_f=0x80 -> that cycle predict_taken_f=0 and branch_state_d loads 00. The next cycle predicts taken. Also assert rst mid-stream -> all lookups miss immediately.
